sha256_compress_ctrl: RTL and testbench
=======================================

Name: sha256_compress_ctrl

Overview:
Drives and consumes the SHA-256 message schedule for one single-block compression.
- Accepts a 256-bit message over a valid/ready handshake.
- Pulses the schedule's init, then steps the round index t through 0..63, asserting shift where required.
- Consumes the returned W_t words for 64 compression rounds and adds the FIPS 180-4 IV.
- Presents the 256-bit digest over a valid/ready handshake.

Parameters:
None. The block is fixed-function SHA-256, and all constants live in the shared package.

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low; one clock domain
msg_block  in  256  message, big-endian; word 0 = [255:224]
msg_valid  in  1  message offered
msg_ready  out  1  high only in IDLE
digest  out  256  H0..H7 concatenated; H0 = [255:224]
digest_valid  out  1  digest offered
digest_ready  in  1  digest taken
busy  out  1  high in any state other than IDLE
err  out  1  one-cycle pulse on schedule protocol error
sched_init  out  1  load pulse to the schedule
sched_shift  out  1  slide request to the schedule
sched_t  out  6  round index to the schedule
sched_w  in  32  W_t from the schedule; registered, one cycle after sched_t
sched_valid  in  1  schedule output valid

Behaviour:
- Reset values:
  - msg_ready = 0, then 1 once in IDLE.
  - digest = 0, digest_valid = 0, busy = 0, err = 0.
  - sched_init = 0, sched_shift = 0, sched_t = 0.
  - Working registers a..h = 0; state = IDLE.
- States: IDLE -> LOAD -> ROUND -> FINAL -> DONE -> IDLE.
- IDLE: msg_ready = 1. On msg_valid & msg_ready, latch msg_block and go to LOAD. Call this clock edge E.
- LOAD, one cycle:
  - sched_init = 1; msg_block is driven to the schedule from the latch.
  - a..h <= IV.
  - Issue counter ti <= 0; go to ROUND.
- ROUND, issue side:
  - sched_t = ti, incrementing each cycle from 0 to 63, then held at 63.
  - sched_shift = 1 iff 15 <= ti <= 62.
- ROUND, consume side:
  - Round r = ti - 1 uses sched_w and K[r].
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[r] + W.
  - T2 = Σ0(a) + Maj(a,b,c).
  - Update: h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2.
  - All arithmetic is mod 2^32; carries are discarded.
- ROUND timing:
  - Issues t = 0..63 on edges E+1..E+64.
  - Compresses round r at edge E+3+r; round 63 completes at E+66.
  - Exits to FINAL after round 63.
- FINAL, one cycle: digest[i] <= IV[i] + working reg[i], mod 2^32. digest_valid <= 1 at edge E+67, and state goes to DONE.
- DONE: digest and digest_valid are held stable until digest_ready is high.
  - On digest_valid & digest_ready: digest_valid <= 0 and state goes to IDLE.
  - digest keeps its last value.
- Accept-to-digest_valid latency is fixed at 67 cycles. The next message is accepted no earlier than 1 cycle after the digest handshake.
- msg_valid while busy: ignored, because msg_ready = 0. The message must stay held by the source.
- sched_valid low on any consume cycle:
  - err = 1 for one cycle; abort to IDLE.
  - digest_valid is not asserted; digest is unchanged.
- digest_ready high outside DONE: no effect.
- Reset asserted mid-operation: all outputs take reset values immediately (asynchronous). A partial digest is never presented.

Decomposition:
- Package sha256_pkg:
  - K[0..63] constant array and IV H0..H7 constants.
  - State enum.
  - Functions Σ0, Σ1, Ch, Maj, rotr.
  - Word width localparam (32).
- Sub-module sha256_round: purely combinational single-round step. Inputs a..h, K, W; outputs next a..h.
- Top-level ownership: FSM, counters, handshake and the feed-forward add.

Test Plan:
1. All-zero 32-byte message, digest_ready tied high -> digest = 66687aadf862bd776c8fc18b8e9f8e20089714856ee233b3902a591d0d5f2925. digest_valid rises exactly 67 cycles after the accept edge; msg_ready = 0 throughout.
2. Schedule interface trace for any message -> sched_init high for exactly 1 cycle. sched_t runs 0,1,...,63 on consecutive cycles. sched_shift is high exactly for t = 15..62 (48 cycles).
3. Random messages, 200 vectors, compared against a software SHA-256 of the 32-byte message -> every digest matches; the digest word order has H0 in [255:224].
4. Backpressure: digest_ready held low 10 cycles after digest_valid, with a second msg_valid held high -> digest stays stable and msg_ready = 0. After the digest handshake, msg_ready = 1 on the next cycle and the second message is accepted.
5. Schedule fault: force sched_valid = 0 during round 20 -> err pulses 1 cycle, block returns to IDLE, digest_valid never rises, and the previous digest is retained.
6. rst_n asserted at round 30 and released 3 cycles later -> all outputs are 0 immediately and msg_ready = 1 after release. A fresh all-zero message then reproduces the digest from scenario 1.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, working-state types and round helper functions
// for the single-block compression controller.
package sha256_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // Packed so that field a lands in [255:224], matching the digest word order.
    typedef struct packed {
        word_t a;
        word_t b;
        word_t c;
        word_t d;
        word_t e;
        word_t f;
        word_t g;
        word_t h;
    } work_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam work_t IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_compress_ctrl_round.sv
// One SHA-256 compression round, purely combinational: current a..h plus K and W
// in, next a..h out. All sums wrap modulo 2^32.
module sha256_round
    import sha256_pkg::*;
(
    input  work_t cur,
    input  word_t k,
    input  word_t w,
    output work_t nxt
);

    word_t t1;
    word_t t2;

    always_comb begin
        t1 = cur.h + big_sigma1(cur.e) + ch(cur.e, cur.f, cur.g) + k + w;
        t2 = big_sigma0(cur.a) + maj(cur.a, cur.b, cur.c);

        nxt.a = t1 + t2;
        nxt.b = cur.a;
        nxt.c = cur.b;
        nxt.d = cur.c;
        nxt.e = cur.d + t1;
        nxt.f = cur.e;
        nxt.g = cur.f;
        nxt.h = cur.g;
    end

endmodule

// File: rtl/sha256_compress_ctrl.sv
// Single-block SHA-256 compression controller: accepts a message, sequences an
// external message schedule, runs 64 rounds and presents the feed-forward digest.
module sha256_compress_ctrl
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] msg_block,
    input  logic         msg_valid,
    output logic         msg_ready,
    output logic [255:0] digest,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic         busy,
    output logic         err,
    output logic         sched_init,
    output logic         sched_shift,
    output logic [5:0]   sched_t,
    output logic [255:0] sched_msg,
    input  logic [31:0]  sched_w,
    input  logic         sched_valid,
    output logic [2:0]   dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; the source holds its payload and valid until that edge.

    state_t       state;
    state_t       state_next;
    logic [255:0] msg_q;
    work_t        work;
    work_t        work_nxt;
    logic [6:0]   ti;
    logic [5:0]   r_idx;
    logic         consume;
    logic         accept;
    logic [255:0] digest_sum;

    // ti counts 0..64; round r = ti-1 is consumed once the first W has arrived.
    assign consume     = (state == ST_ROUND) && (ti != 7'd0);
    assign accept      = (state == ST_IDLE) && msg_valid && msg_ready;
    assign r_idx       = ti[5:0] - 6'd1;

    assign busy        = (state != ST_IDLE);
    assign sched_init  = (state == ST_LOAD);
    assign sched_shift = (state == ST_ROUND) && (ti >= 7'd15) && (ti <= 7'd62);
    assign sched_t     = (state != ST_ROUND) ? 6'd0 :
                         (ti[6] ? 6'd63 : ti[5:0]);
    assign sched_msg   = msg_q;
    assign dbg_state   = state;

    sha256_round u_round (
        .cur (work),
        .k   (K[r_idx]),
        .w   (sched_w),
        .nxt (work_nxt)
    );

    always_comb begin
        digest_sum = '0;
        for (int i = 0; i < 8; i++) begin
            digest_sum[255-32*i -: 32] = IV[255-32*i -: 32] + work[255-32*i -: 32];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept) state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_ROUND;
            ST_ROUND: begin
                if (consume && !sched_valid) state_next = ST_IDLE;
                else if (ti == 7'd64)        state_next = ST_FINAL;
            end
            ST_FINAL: state_next = ST_DONE;
            ST_DONE:  if (digest_valid && digest_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            msg_ready    <= 1'b0;
            msg_q        <= '0;
            work         <= '0;
            ti           <= '0;
            digest       <= '0;
            digest_valid <= 1'b0;
            err          <= 1'b0;
        end else begin
            state     <= state_next;
            msg_ready <= (state_next == ST_IDLE);
            err       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) msg_q <= msg_block;
                end
                ST_LOAD: begin
                    work <= IV;
                    ti   <= '0;
                end
                ST_ROUND: begin
                    // A missing W aborts the block; the old digest stays visible.
                    if (consume && !sched_valid) begin
                        err <= 1'b1;
                    end else begin
                        if (consume) work <= work_nxt;
                        if (ti != 7'd64) ti <= ti + 7'd1;
                    end
                end
                ST_FINAL: begin
                    digest       <= digest_sum;
                    digest_valid <= 1'b1;
                end
                ST_DONE: begin
                    if (digest_ready) digest_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_compress_ctrl.sv
// Directed bench for sha256_compress_ctrl with a behavioural message schedule
// and an independent software SHA-256 reference for single 32-byte messages.
module tb_sha256_compress_ctrl;

    localparam logic [255:0] ZERO_DIGEST =
        256'h66687aadf862bd776c8fc18b8e9f8e20089714856ee233b3902a591d0d5f2925;

    localparam logic [31:0] TK [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] TIV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    logic         clk;
    logic         rst_n;
    logic [255:0] msg_block;
    logic         msg_valid;
    logic         msg_ready;
    logic [255:0] digest;
    logic         digest_valid;
    logic         digest_ready;
    logic         busy;
    logic         err;
    logic         sched_init;
    logic         sched_shift;
    logic [5:0]   sched_t;
    logic [255:0] sched_msg;
    logic [31:0]  sched_w;
    logic         sched_valid;
    logic [2:0]   dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [255:0] exp_q[$];

    logic [5:0] tr_t     [200];
    logic       tr_init  [200];
    logic       tr_shift [200];
    int         rdy_cnt;

    sha256_compress_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .msg_block    (msg_block),
        .msg_valid    (msg_valid),
        .msg_ready    (msg_ready),
        .digest       (digest),
        .digest_valid (digest_valid),
        .digest_ready (digest_ready),
        .busy         (busy),
        .err          (err),
        .sched_init   (sched_init),
        .sched_shift  (sched_shift),
        .sched_t      (sched_t),
        .sched_msg    (sched_msg),
        .sched_w      (sched_w),
        .sched_valid  (sched_valid),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0][31:0] tb_expand(input logic [255:0] m);
        logic [63:0][31:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) w[i] = m[255-32*i -: 32];
        w[8]  = 32'h80000000;
        w[15] = 32'd256;
        for (int i = 16; i < 64; i++)
            w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        return w;
    endfunction

    function automatic logic [255:0] sha_ref(input logic [255:0] m);
        logic [63:0][31:0] w;
        logic [31:0] v [8];
        logic [31:0] t1;
        logic [31:0] t2;
        logic [255:0] res;
        w = tb_expand(m);
        for (int i = 0; i < 8; i++) v[i] = TIV[255-32*i -: 32];
        for (int r = 0; r < 64; r++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + TK[r] + w[r];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) res[255-32*i -: 32] = TIV[255-32*i -: 32] + v[i];
        return res;
    endfunction

    // Behavioural schedule: loads on init, returns W[sched_t] one cycle later.
    logic [63:0][31:0] w_tab;
    always @(posedge clk) begin
        if (sched_init) w_tab <= tb_expand(sched_msg);
        sched_w <= w_tab[sched_t];
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: each digest handshake is compared with the oldest expected digest.
    always @(negedge clk) begin
        if (rst_n && digest_valid && digest_ready) begin
            if (exp_q.size() == 0) check("digest_unexpected", 256'(1), 256'(0));
            else                   check("digest", digest, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_msg(input logic [255:0] m);
        logic ready_now;
        int   guard;
        guard     = 0;
        msg_block = m;
        msg_valid = 1'b1;
        ready_now = 1'b0;
        while (!ready_now && guard < 200) begin
            ready_now = msg_ready;
            @(posedge clk); #1;
            guard++;
        end
        msg_valid = 1'b0;
        check("accept", 256'(ready_now), 256'(1));
    endtask

    task automatic wait_digest(input string tag);
        int lat;
        lat     = 0;
        rdy_cnt = 0;
        while (!digest_valid && lat < 199) begin
            tr_t[lat]     = sched_t;
            tr_init[lat]  = sched_init;
            tr_shift[lat] = sched_shift;
            if (msg_ready) rdy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 256'(lat), 256'(67));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [255:0] m;
        logic [255:0] last_exp;
        logic [255:0] d0;
        int           diffs;
        int           cnt;
        int           icnt, ipos, scnt, sbad, terr;

        rst_n        = 1'b0;
        msg_block    = '0;
        msg_valid    = 1'b0;
        digest_ready = 1'b1;
        sched_valid  = 1'b1;
        #2;
        check("rst_msg_ready", 256'(msg_ready), 256'(0));
        check("rst_digest", digest, 256'(0));
        check("rst_digest_valid", 256'(digest_valid), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_sched", 256'({err, sched_init, sched_shift, sched_t}), 256'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_msg_ready", 256'(msg_ready), 256'(1));

        // All-zero message with digest_ready tied high
        exp_q.push_back(ZERO_DIGEST);
        send_msg('0);
        wait_digest("zero");
        check("zero_ready_low_busy", 256'(rdy_cnt), 256'(0));
        @(posedge clk); #1;

        // Schedule interface trace of that transaction
        icnt = 0; ipos = -1; scnt = 0; sbad = 0; terr = 0;
        for (int k = 0; k < 67; k++) begin
            if (tr_init[k]) begin icnt++; ipos = k; end
            if (tr_shift[k]) begin
                scnt++;
                if (k < 16 || k > 63) sbad++;
            end
            if (k >= 1 && k <= 64 && tr_t[k] != 6'(k - 1)) terr++;
        end
        check("init_count", 256'(icnt), 256'(1));
        check("init_pos", 256'(ipos), 256'(0));
        check("t_sequence_errs", 256'(terr), 256'(0));
        check("shift_count", 256'(scnt), 256'(48));
        check("shift_misplaced", 256'(sbad), 256'(0));

        // Random messages
        for (int v = 0; v < 200; v++) begin
            for (int j = 0; j < 8; j++) m[255-32*j -: 32] = $urandom_range(32'hffff_ffff, 0);
            exp_q.push_back(sha_ref(m));
            send_msg(m);
            wait_digest("rand");
            @(posedge clk); #1;
        end

        // Backpressure with a second message waiting
        digest_ready = 1'b0;
        m = {8{32'hdeadbeef}};
        exp_q.push_back(sha_ref(m));
        send_msg(m);
        wait_digest("bp1");
        m = {8{32'h01234567}};
        last_exp = sha_ref(m);
        exp_q.push_back(last_exp);
        msg_block = m;
        msg_valid = 1'b1;
        d0 = digest;
        diffs = 0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (digest !== d0 || digest_valid !== 1'b1) diffs++;
            if (msg_ready) cnt++;
        end
        check("bp_stable", 256'(diffs), 256'(0));
        check("bp_ready_low", 256'(cnt), 256'(0));
        digest_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_valid_drop", 256'(digest_valid), 256'(0));
        check("bp_ready_next", 256'(msg_ready), 256'(1));
        @(posedge clk); #1;
        check("bp_second_accepted", 256'({busy, msg_ready}), 256'(2'b10));
        msg_valid = 1'b0;
        wait_digest("bp2");
        @(posedge clk); #1;

        // Schedule fault during round 20
        send_msg({8{32'hcafef00d}});
        repeat (21) @(posedge clk);
        #1 sched_valid = 1'b0;
        @(posedge clk); #1;
        sched_valid = 1'b1;
        check("fault_err", 256'(err), 256'(1));
        check("fault_idle", 256'({busy, msg_ready}), 256'(2'b01));
        @(posedge clk); #1;
        check("fault_err_pulse", 256'(err), 256'(0));
        cnt = 0;
        for (int k = 0; k < 70; k++) begin
            if (digest_valid) cnt++;
            @(posedge clk); #1;
        end
        check("fault_no_valid", 256'(cnt), 256'(0));
        check("fault_digest_kept", digest, last_exp);

        // Asynchronous reset around round 30
        send_msg({8{32'h5a5a5a5a}});
        repeat (32) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_digest", digest, 256'(0));
        check("mid_rst_flags", 256'({digest_valid, busy, err, msg_ready}), 256'(0));
        check("mid_rst_sched", 256'({sched_init, sched_shift, sched_t}), 256'(0));
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", 256'(msg_ready), 256'(1));
        exp_q.push_back(ZERO_DIGEST);
        send_msg('0);
        wait_digest("zero2");
        @(posedge clk); #1;

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 256'(exp_q.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
